instr_issue_queue: RTL and testbench

- Two-wide, in-order FIFO between the Resolver output and the two Comparators.
- Absorbs back-pressure from the reservation-station side so that a full station does not stall the front end immediately.
- Discards speculative entries on a branch mispredict and promotes them on a branch commit.
- Entries carry a packed instruction-info payload (address, immediate, name, type, regs, flags) plus one speculation tag bit.

---
 rtl/instr_issue_queue.sv | 124 ++++++++++++
 tb/tb_instr_issue_queue.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/instr_issue_queue.sv
// Two-wide in-order issue queue between the Resolver and the Comparators.
// Show-ahead outputs; speculative entries are dropped on mispredict and promoted on commit.
module instr_issue_queue #(
  parameter int DEPTH  = 8,
  parameter int INFO_W = 160
) (
  input  logic                            i_clock,
  input  logic                            i_reset,
  input  logic [1:0]                      i_in_valid,
  input  logic [1:0][INFO_W-1:0]          i_in_info,
  input  logic [1:0]                      i_in_tag,
  output logic                            o_in_ready,
  output logic [1:0]                      o_out_valid,
  output logic [1:0][INFO_W-1:0]          o_out_info,
  output logic [1:0]                      o_out_tag,
  input  logic [1:0]                      i_out_ready,
  input  logic                            i_halt,
  input  logic                            i_clear_tag,
  input  logic                            i_delete_tag,
  input  logic                            i_flush,
  output logic [$clog2(DEPTH+1)-1:0]      o_count,
  output logic                            o_empty,
  output logic                            o_full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [INFO_W-1:0] mem_r [DEPTH];
  logic [DEPTH-1:0]  tag_r;
  logic [PW-1:0]     head_r, tail_r;
  logic [CW-1:0]     count_r;

  logic [PW-1:0]     rd1_s, tail_base_s, wr0_s, wr1_s, head_n_s, tail_n_s;
  logic [CW-1:0]     del_off_s, eff_len_s, pops_s, pushes_s, count_n_s;
  logic              del_hit_s, trunc_s, pop0_s, pop1_s, acc0_s, acc1_s;

  // Show-ahead read of the two oldest entries; unused slots read as zero.
  always_comb begin
    rd1_s          = head_r + PW'(1'b1);
    o_in_ready     = (count_r <= CW'(DEPTH-2));
    o_out_valid[0] = (count_r >= CW'(1));
    o_out_valid[1] = (count_r >= CW'(2));
    o_out_info[0]  = o_out_valid[0] ? mem_r[head_r] : {INFO_W{1'b0}};
    o_out_info[1]  = o_out_valid[1] ? mem_r[rd1_s]  : {INFO_W{1'b0}};
    o_out_tag[0]   = o_out_valid[0] ? tag_r[head_r] : 1'b0;
    o_out_tag[1]   = o_out_valid[1] ? tag_r[rd1_s]  : 1'b0;
    o_count        = count_r;
    o_empty        = (count_r == CW'(0));
    o_full         = (count_r == CW'(DEPTH));
  end

  // Locate the oldest tagged entry, then work out pops, pushes and next pointers.
  always_comb begin
    del_hit_s = 1'b0;
    del_off_s = CW'(0);
    for (int i = 0; i < DEPTH; i++) begin
      del_off_s = (!del_hit_s && (CW'(i) < count_r) && tag_r[head_r + PW'(i)]) ? CW'(i) : del_off_s;
      del_hit_s = del_hit_s | ((CW'(i) < count_r) && tag_r[head_r + PW'(i)]);
    end
    trunc_s   = i_delete_tag && del_hit_s;
    eff_len_s = trunc_s ? del_off_s : count_r;
    // Pops may only take entries that survive a same-cycle truncation.
    pop0_s    = o_out_valid[0] && i_out_ready[0] && !i_halt && (eff_len_s >= CW'(1));
    pop1_s    = pop0_s && o_out_valid[1] && i_out_ready[1] && (eff_len_s >= CW'(2));
    acc0_s    = o_in_ready && i_in_valid[0] && !i_flush && !(i_delete_tag && i_in_tag[0]);
    acc1_s    = o_in_ready && i_in_valid[1] && !i_flush && !(i_delete_tag && i_in_tag[1]);
    pops_s    = CW'(pop0_s) + CW'(pop1_s);
    pushes_s  = CW'(acc0_s) + CW'(acc1_s);
    tail_base_s = trunc_s ? (head_r + PW'(del_off_s)) : tail_r;
    wr0_s     = tail_base_s;
    wr1_s     = tail_base_s + PW'(acc0_s);
    if (i_flush) begin
      head_n_s  = PW'(0);
      tail_n_s  = PW'(0);
      count_n_s = CW'(0);
    end else begin
      head_n_s  = head_r + PW'(pops_s);
      tail_n_s  = tail_base_s + PW'(pushes_s);
      count_n_s = eff_len_s - pops_s + pushes_s;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      head_r  <= PW'(0);
      tail_r  <= PW'(0);
      count_r <= CW'(0);
    end else begin
      head_r  <= head_n_s;
      tail_r  <= tail_n_s;
      count_r <= count_n_s;
    end
  end

  // Speculation tags: commit clears every stored tag, new entries keep their own.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      tag_r <= {DEPTH{1'b0}};
    end else begin
      if (i_clear_tag && !i_flush && !i_delete_tag) begin
        tag_r <= {DEPTH{1'b0}};
      end
      if (acc0_s) begin
        tag_r[wr0_s] <= i_in_tag[0];
      end
      if (acc1_s) begin
        tag_r[wr1_s] <= i_in_tag[1];
      end
    end
  end

  // Payload storage; slots beyond the tail are don't-care so no reset is needed.
  always_ff @(posedge i_clock) begin
    if (acc0_s) begin
      mem_r[wr0_s] <= i_in_info[0];
    end
    if (acc1_s) begin
      mem_r[wr1_s] <= i_in_info[1];
    end
  end

endmodule

// File: tb/tb_instr_issue_queue.sv
// Directed testbench for instr_issue_queue with hand-computed expectations.
module tb_instr_issue_queue;

  logic                   i_clock = 1'b0;
  logic                   i_reset;
  logic [1:0]             i_in_valid;
  logic [1:0][159:0]      i_in_info;
  logic [1:0]             i_in_tag;
  logic                   o_in_ready;
  logic [1:0]             o_out_valid;
  logic [1:0][159:0]      o_out_info;
  logic [1:0]             o_out_tag;
  logic [1:0]             i_out_ready;
  logic                   i_halt, i_clear_tag, i_delete_tag, i_flush;
  logic [3:0]             o_count;
  logic                   o_empty, o_full;

  int tests_run = 0;
  int tests_failed = 0;

  instr_issue_queue #(.DEPTH(8), .INFO_W(160)) dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_in_valid(i_in_valid), .i_in_info(i_in_info), .i_in_tag(i_in_tag),
    .o_in_ready(o_in_ready), .o_out_valid(o_out_valid), .o_out_info(o_out_info),
    .o_out_tag(o_out_tag), .i_out_ready(i_out_ready), .i_halt(i_halt),
    .i_clear_tag(i_clear_tag), .i_delete_tag(i_delete_tag), .i_flush(i_flush),
    .o_count(o_count), .o_empty(o_empty), .o_full(o_full)
  );

  always #5 i_clock = ~i_clock;

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic drive_in(input logic [1:0] v, input logic [159:0] a, input logic [159:0] b,
                          input logic [1:0] t);
    i_in_valid   = v;
    i_in_info[0] = a;
    i_in_info[1] = b;
    i_in_tag     = t;
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_halt = 1'b0; i_clear_tag = 1'b0; i_delete_tag = 1'b0; i_flush = 1'b0;
    i_out_ready = 2'b00;
    drive_in(2'b00, 160'd0, 160'd0, 2'b00);
    tick(); tick();
    tests_run++; if (o_out_valid !== 2'b00) begin tests_failed++; $display("FAIL reset_valid: got %b want 00", o_out_valid); end
    tests_run++; if (o_out_info !== 320'd0) begin tests_failed++; $display("FAIL reset_info: got %h want 0", o_out_info); end
    tests_run++; if (o_out_tag !== 2'b00) begin tests_failed++; $display("FAIL reset_tag: got %b want 00", o_out_tag); end
    tests_run++; if ({o_in_ready, o_empty, o_full} !== 3'b110) begin tests_failed++; $display("FAIL reset_flags: got %b want 110", {o_in_ready, o_empty, o_full}); end
    tests_run++; if (o_count !== 4'd0) begin tests_failed++; $display("FAIL reset_count: got %0d want 0", o_count); end
    i_reset = 1'b0;
    tick();
  endtask

  task automatic test_push_basic();
    drive_in(2'b11, 160'd1, 160'd2, 2'b00);
    tick();
    drive_in(2'b00, 160'd0, 160'd0, 2'b00);
    tests_run++; if (o_out_valid !== 2'b11) begin tests_failed++; $display("FAIL push_valid: got %b want 11", o_out_valid); end
    tests_run++; if (o_out_info[0] !== 160'd1 || o_out_info[1] !== 160'd2) begin tests_failed++; $display("FAIL push_info: got %0d/%0d want 1/2", o_out_info[0], o_out_info[1]); end
    tests_run++; if (o_count !== 4'd2 || o_empty !== 1'b0) begin tests_failed++; $display("FAIL push_count: got %0d empty %b want 2 empty 0", o_count, o_empty); end
  endtask

  task automatic test_fill();
    drive_in(2'b11, 160'd3, 160'd4, 2'b00); tick();
    drive_in(2'b11, 160'd5, 160'd6, 2'b00); tick();
    tests_run++; if (o_count !== 4'd6 || o_in_ready !== 1'b1) begin tests_failed++; $display("FAIL fill_six: got count %0d ready %b want 6 ready 1", o_count, o_in_ready); end
    drive_in(2'b11, 160'd7, 160'd8, 2'b00); tick();
    tests_run++; if (o_count !== 4'd8 || o_in_ready !== 1'b0 || o_full !== 1'b1) begin tests_failed++; $display("FAIL fill_full: got count %0d ready %b full %b want 8 0 1", o_count, o_in_ready, o_full); end
    drive_in(2'b11, 160'd9, 160'd10, 2'b00); tick();
    tests_run++; if (o_count !== 4'd8) begin tests_failed++; $display("FAIL full_ignore_count: got %0d want 8", o_count); end
    tests_run++; if (o_out_info[0] !== 160'd1 || o_out_info[1] !== 160'd2) begin tests_failed++; $display("FAIL full_ignore_info: got %0d/%0d want 1/2", o_out_info[0], o_out_info[1]); end
  endtask

  task automatic test_back_to_back();
    i_out_ready = 2'b11;
    drive_in(2'b11, 160'd9, 160'd10, 2'b00); tick();
    tests_run++; if (o_count !== 4'd6 || o_in_ready !== 1'b1) begin tests_failed++; $display("FAIL full_pop_count: got %0d ready %b want 6 ready 1", o_count, o_in_ready); end
    tests_run++; if (o_out_info[0] !== 160'd3 || o_out_info[1] !== 160'd4) begin tests_failed++; $display("FAIL full_pop_info: got %0d/%0d want 3/4", o_out_info[0], o_out_info[1]); end
    drive_in(2'b11, 160'd11, 160'd12, 2'b00); tick();
    tests_run++; if (o_count !== 4'd6) begin tests_failed++; $display("FAIL b2b_count: got %0d want 6", o_count); end
    tests_run++; if (o_out_info[0] !== 160'd5 || o_out_info[1] !== 160'd6) begin tests_failed++; $display("FAIL b2b_info: got %0d/%0d want 5/6", o_out_info[0], o_out_info[1]); end
    drive_in(2'b00, 160'd0, 160'd0, 2'b00); tick();
    tests_run++; if (o_count !== 4'd4 || o_out_info[0] !== 160'd7 || o_out_info[1] !== 160'd8) begin tests_failed++; $display("FAIL drain_a: got count %0d info %0d/%0d want 4 7/8", o_count, o_out_info[0], o_out_info[1]); end
    tick();
    tests_run++; if (o_count !== 4'd2 || o_out_info[0] !== 160'd11 || o_out_info[1] !== 160'd12) begin tests_failed++; $display("FAIL wrap_order: got count %0d info %0d/%0d want 2 11/12", o_count, o_out_info[0], o_out_info[1]); end
    tick();
    tests_run++; if (o_count !== 4'd0 || o_empty !== 1'b1 || o_out_valid !== 2'b00) begin tests_failed++; $display("FAIL drain_empty: got count %0d empty %b valid %b want 0 1 00", o_count, o_empty, o_out_valid); end
    i_out_ready = 2'b00;
  endtask

  task automatic test_delete_tag();
    drive_in(2'b11, 160'd20, 160'd21, 2'b00); tick();
    drive_in(2'b11, 160'd22, 160'd23, 2'b11); tick();
    tests_run++; if (o_count !== 4'd4 || o_out_tag !== 2'b00) begin tests_failed++; $display("FAIL del_setup: got count %0d tag %b want 4 00", o_count, o_out_tag); end
    drive_in(2'b01, 160'd24, 160'd0, 2'b00);
    i_out_ready = 2'b01; i_delete_tag = 1'b1;
    tick();
    drive_in(2'b00, 160'd0, 160'd0, 2'b00);
    i_out_ready = 2'b00; i_delete_tag = 1'b0;
    tests_run++; if (o_count !== 4'd2) begin tests_failed++; $display("FAIL del_count: got %0d want 2", o_count); end
    tests_run++; if (o_out_info[0] !== 160'd21 || o_out_info[1] !== 160'd24) begin tests_failed++; $display("FAIL del_info: got %0d/%0d want 21/24", o_out_info[0], o_out_info[1]); end
    tests_run++; if (o_out_tag !== 2'b00) begin tests_failed++; $display("FAIL del_tag: got %b want 00", o_out_tag); end
    i_out_ready = 2'b11; tick(); i_out_ready = 2'b00;
    tests_run++; if (o_count !== 4'd0) begin tests_failed++; $display("FAIL del_drain: got %0d want 0", o_count); end
  endtask

  task automatic test_clear_tag();
    drive_in(2'b11, 160'd30, 160'd31, 2'b11); tick();
    tests_run++; if (o_out_tag !== 2'b11) begin tests_failed++; $display("FAIL clr_setup_tag: got %b want 11", o_out_tag); end
    drive_in(2'b01, 160'd32, 160'd0, 2'b01);
    i_clear_tag = 1'b1;
    tick();
    drive_in(2'b00, 160'd0, 160'd0, 2'b00);
    i_clear_tag = 1'b0;
    tests_run++; if (o_count !== 4'd3 || o_out_tag !== 2'b00) begin tests_failed++; $display("FAIL clr_tags: got count %0d tag %b want 3 00", o_count, o_out_tag); end
    i_out_ready = 2'b11; tick();
    tests_run++; if (o_count !== 4'd1 || o_out_info[0] !== 160'd32 || o_out_tag !== 2'b01) begin tests_failed++; $display("FAIL clr_new_tag: got count %0d info %0d tag %b want 1 32 01", o_count, o_out_info[0], o_out_tag); end
    tick(); i_out_ready = 2'b00;
  endtask

  task automatic test_halt_flush_reset();
    drive_in(2'b11, 160'd40, 160'd41, 2'b00); tick();
    drive_in(2'b11, 160'd42, 160'd43, 2'b00); tick();
    drive_in(2'b01, 160'd44, 160'd0, 2'b00); tick();
    drive_in(2'b00, 160'd0, 160'd0, 2'b00);
    i_halt = 1'b1; i_out_ready = 2'b11; tick();
    tests_run++; if (o_count !== 4'd5 || o_out_info[0] !== 160'd40) begin tests_failed++; $display("FAIL halt: got count %0d info %0d want 5 40", o_count, o_out_info[0]); end
    i_halt = 1'b0; i_flush = 1'b1;
    drive_in(2'b11, 160'd45, 160'd46, 2'b00);
    i_reset = 1'b1; #1;
    tests_run++; if (o_count !== 4'd0 || o_out_valid !== 2'b00 || o_out_info !== 320'd0 || o_out_tag !== 2'b00) begin tests_failed++; $display("FAIL async_reset_out: got count %0d valid %b tag %b", o_count, o_out_valid, o_out_tag); end
    tests_run++; if ({o_in_ready, o_empty, o_full} !== 3'b110) begin tests_failed++; $display("FAIL async_reset_flags: got %b want 110", {o_in_ready, o_empty, o_full}); end
    #1; i_reset = 1'b0;
    tick();
    tests_run++; if (o_count !== 4'd0 || o_empty !== 1'b1) begin tests_failed++; $display("FAIL flush_after_reset: got %0d want 0", o_count); end
    i_flush = 1'b0; i_out_ready = 2'b00;
    drive_in(2'b10, 160'd0, 160'd50, 2'b00); tick();
    tests_run++; if (o_count !== 4'd1 || o_out_valid !== 2'b01 || o_out_info[0] !== 160'd50) begin tests_failed++; $display("FAIL slot1_only: got count %0d valid %b info %0d want 1 01 50", o_count, o_out_valid, o_out_info[0]); end
    drive_in(2'b11, 160'd51, 160'd52, 2'b00);
    i_flush = 1'b1; i_out_ready = 2'b11; tick();
    i_flush = 1'b0; i_out_ready = 2'b00;
    drive_in(2'b00, 160'd0, 160'd0, 2'b00);
    tests_run++; if (o_count !== 4'd0 || o_empty !== 1'b1) begin tests_failed++; $display("FAIL flush_discard: got %0d want 0", o_count); end
  endtask

  initial begin
    test_reset();
    test_push_basic();
    test_fill();
    test_back_to_back();
    test_delete_tag();
    test_clear_tag();
    test_halt_flush_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
